// File: rtl/ula_seq.sv
// ula_seq: multi-cycle accumulator-datapath ALU with valid/ready handshakes and sticky status flags.
// Define ULA_DIV_EN to build the iterative restoring divider; otherwise DIV reports divide-by-zero.
module ula_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [3:0]       ULAOPCode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Outp,
    output logic [3:0]       SRFlags,
    input  logic [3:0]       SRSignals,
    output logic             Busy
);

    localparam int               MSB      = WIDTH - 1;
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_ASL = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e             state;
    logic [SHW-1:0]     cnt_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
`ifdef ULA_DIV_EN
    logic               is_div_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dsor_q;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;
`endif

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[MSB] ? -x : x;
    endfunction

    // Single-cycle operations, evaluated on the live inputs at the transfer.
    logic [WIDTH-1:0] sum, diff, sc_res;
    logic             nb_msb, shamt_ok, sc_v, sc_dz, start_iter;

    // NOTE: every signal assigned here gets a default first, so no path leaves it holding a value (no latch).
    always_comb begin
        sum        = InputA + InputB;
        diff       = InputA - InputB;
        // -B keeps B's sign bit only for 0 and MIN; everything else flips it.
        nb_msb     = ((InputB & ~MIN_VAL) == '0) ? InputB[MSB] : ~InputB[MSB];
        shamt_ok   = (InputB >> SHW) == '0;
        sc_res     = '0;
        sc_v       = 1'b0;
        sc_dz      = 1'b0;
        start_iter = 1'b0;
        case (ULAOPCode)
            OP_ADD: begin
                sc_res = sum;
                sc_v   = (InputA[MSB] == InputB[MSB]) && (sum[MSB] != InputA[MSB]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_v   = (InputA[MSB] == nb_msb) && (diff[MSB] != InputA[MSB]);
            end
            OP_AND: sc_res = InputA & InputB;
            OP_OR:  sc_res = InputA | InputB;
            OP_XOR: sc_res = InputA ^ InputB;
            OP_ASL: sc_res = shamt_ok ? (InputA << InputB[SHW-1:0]) : '0;
            OP_LSR: sc_res = shamt_ok ? (InputA >> InputB[SHW-1:0]) : '0;
            OP_MUL: start_iter = 1'b1;
`ifdef ULA_DIV_EN
            OP_DIV: begin
                if (InputB == '0) sc_dz = 1'b1;
                else              start_iter = 1'b1;
            end
`else
            OP_DIV: sc_dz = 1'b1;
`endif
            default: ;
        endcase
    end

    // One iteration step of the shift-add multiplier / restoring divider, plus sign fix-up.
    logic [2*WIDTH-1:0] acc_nx, prod;
    logic [WIDTH-1:0]   it_res;
    logic               it_v;

    always_comb begin
        acc_nx = mplier_q[0] ? acc_q + mcand_q : acc_q;
        prod   = neg_q ? -acc_nx : acc_nx;
        it_res = prod[WIDTH-1:0];
        // The product fits in WIDTH signed bits only if its top WIDTH+1 bits are a pure sign extension.
        it_v   = !((&prod[2*WIDTH-1:MSB]) || !(|prod[2*WIDTH-1:MSB]));
`ifdef ULA_DIV_EN
        rem_sh = {rem_q, quo_q[MSB]};
        trial  = rem_sh - {1'b0, dsor_q};
        rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        if (is_div_q) begin
            it_res = neg_q ? -quo_nx : quo_nx;
            it_v   = ovf_q;
        end
`endif
    end

    // Result/flag load strobe: single-cycle ops at the transfer, iterative ops on their last step.
    logic             load_en, load_v, load_dz;
    logic [WIDTH-1:0] load_res;

    always_comb begin
        load_en  = 1'b0;
        load_res = sc_res;
        load_v   = sc_v;
        load_dz  = sc_dz;
        if (state == S_IDLE) begin
            load_en = InValid && InReady && !start_iter;
        end else if (state == S_BUSY && cnt_q == CNT_LAST) begin
            load_en  = 1'b1;
            load_res = it_res;
            load_v   = it_v;
            load_dz  = 1'b0;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            // NOTE: the iteration datapath is reset too, so an aborted operation leaves nothing behind.
            state    <= S_IDLE;
            InReady  <= 1'b0;
            OutValid <= 1'b0;
            Outp     <= '0;
            SRFlags  <= '0;
            Busy     <= 1'b0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`ifdef ULA_DIV_EN
            is_div_q <= 1'b0;
            ovf_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsor_q   <= '0;
`endif
        end else begin
            if (load_en) begin
                Outp    <= load_res;
                SRFlags <= {SRFlags[3] | load_dz, SRFlags[2] | load_v,
                            load_res == '0, load_res[MSB]};
            end else begin
                SRFlags <= SRFlags & ~{SRSignals[3], SRSignals[0], SRSignals[2], SRSignals[1]};
            end

            case (state)
                S_IDLE: begin
                    if (InValid && InReady) begin
                        InReady <= 1'b0;
                        if (start_iter) begin
                            state    <= S_BUSY;
                            Busy     <= 1'b1;
                            cnt_q    <= '0;
                            neg_q    <= InputA[MSB] ^ InputB[MSB];
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, abs_val(InputA)};
                            mplier_q <= abs_val(InputB);
`ifdef ULA_DIV_EN
                            is_div_q <= (ULAOPCode == OP_DIV);
                            ovf_q    <= (InputA == MIN_VAL) && (InputB == '1);
                            rem_q    <= '0;
                            quo_q    <= abs_val(InputA);
                            dsor_q   <= abs_val(InputB);
`endif
                        end else begin
                            state    <= S_DONE;
                            OutValid <= 1'b1;
                        end
                    end else begin
                        InReady <= 1'b1;
                    end
                end
                S_BUSY: begin
                    cnt_q    <= cnt_q + 1'b1;
                    acc_q    <= acc_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
`ifdef ULA_DIV_EN
                    rem_q    <= rem_nx;
                    quo_q    <= quo_nx;
`endif
                    if (cnt_q == CNT_LAST) begin
                        state    <= S_DONE;
                        Busy     <= 1'b0;
                        OutValid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (OutReady) begin
                        state    <= S_IDLE;
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
